timer_multi: RTL and testbench

- Parametrised multi-channel up-counting timer peripheral for the tinyriscv bus; successor to the single-channel 32-bit timer.
- Each channel adds a prescaler, one-shot/auto-reload mode, and a per-channel write-1-to-clear pending flag.
- All channel interrupts are ORed onto one line for the core's interrupt input.
- Bus reads are registered and acknowledged one cycle after the request.

---
 rtl/timer_multi.sv | 170 +++++++++++++++++
 tb/tb_timer_multi.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_multi.sv
`default_nettype none
// ============================================================================
// Module   : timer_multi
// Purpose  : Multi-channel up-counting timer with prescaler, one-shot or
//            auto-reload mode, W1C pending flags and one ORed interrupt line.
// Revision : 1.0 - initial release
// ============================================================================
module timer_multi #(
  parameter int NUM_CH      = 4,
  parameter int CNT_WIDTH   = 32,
  parameter int PRESC_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic        req_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        int_sig_o
);

  localparam logic [3:0] OFF_CTRL  = 4'h0;
  localparam logic [3:0] OFF_COUNT = 4'h4;
  localparam logic [3:0] OFF_VALUE = 4'h8;
  localparam logic [8:0] ADDR_STAT = 9'h100;

  // Address decode: bits [7:4] pick the channel, [3:0] the register.
  logic [3:0] ch_sel;
  logic [3:0] off;
  logic       in_ch_space;
  logic       is_status;
  logic       wr;
  logic       unused_addr;

  assign ch_sel      = addr_i[7:4];
  assign off         = addr_i[3:0];
  assign in_ch_space = ~addr_i[8];
  assign is_status   = (addr_i[8:0] == ADDR_STAT);
  assign wr          = req_i & we_i;
  assign unused_addr = ^addr_i[31:9];

  // Per-channel state gathered for the read mux and interrupt OR.
  logic [NUM_CH-1:0]      en_vec;
  logic [NUM_CH-1:0]      ie_vec;
  logic [NUM_CH-1:0]      pend_vec;
  logic [NUM_CH-1:0]      mode_vec;
  logic [PRESC_WIDTH-1:0] presc_arr [NUM_CH];
  logic [CNT_WIDTH-1:0]   count_arr [NUM_CH];
  logic [CNT_WIDTH-1:0]   value_arr [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic                   en;
    logic                   int_en;
    logic                   pending;
    logic                   mode;
    logic [PRESC_WIDTH-1:0] presc;
    logic [PRESC_WIDTH-1:0] pre_cnt;
    logic [CNT_WIDTH-1:0]   count;
    logic [CNT_WIDTH-1:0]   value;
    logic                   sel;
    logic                   wr_ctrl;
    logic                   wr_value;
    logic                   tick;
    logic                   expire;

    assign sel      = in_ch_space && (ch_sel == 4'(g));
    assign wr_ctrl  = wr && sel && (off == OFF_CTRL);
    assign wr_value = wr && sel && (off == OFF_VALUE);
    // >= keeps the prescaler bounded if presc is lowered mid-period.
    assign tick     = en && (pre_cnt >= presc);
    assign expire   = tick && (count >= value);

    // Control/VALUE registers; a CTRL write overrides one-shot auto-disable,
    // and an expiry overrides a same-edge W1C of pending.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        en      <= 1'b0;
        int_en  <= 1'b0;
        pending <= 1'b0;
        mode    <= 1'b0;
        presc   <= '0;
        value   <= '0;
      end else begin
        if (wr_ctrl) begin
          en     <= data_i[0];
          int_en <= data_i[1];
          mode   <= data_i[3];
          presc  <= data_i[8 +: PRESC_WIDTH];
        end else if (expire && !mode) begin
          en <= 1'b0;
        end
        if (expire) begin
          pending <= 1'b1;
        end else if (wr_ctrl && data_i[2]) begin
          pending <= 1'b0;
        end
        if (wr_value) begin
          value <= data_i[CNT_WIDTH-1:0];
        end
      end
    end

    // Prescaler and main counter; disabled channels hold both at zero.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        count   <= '0;
        pre_cnt <= '0;
      end else if (!en || (wr_ctrl && !data_i[0])) begin
        count   <= '0;
        pre_cnt <= '0;
      end else if (tick) begin
        pre_cnt <= '0;
        count   <= expire ? '0 : count + 1'b1;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end
    end

    assign en_vec[g]    = en;
    assign ie_vec[g]    = int_en;
    assign pend_vec[g]  = pending;
    assign mode_vec[g]  = mode;
    assign presc_arr[g] = presc;
    assign count_arr[g] = count;
    assign value_arr[g] = value;
  end

  // Read mux: unmapped offsets and absent channels return zero.
  logic [31:0] rdata;
  always_comb begin
    rdata = '0;
    if (is_status) begin
      rdata[NUM_CH-1:0] = pend_vec;
    end else if (in_ch_space) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_sel == 4'(i)) begin
          case (off)
            OFF_CTRL: begin
              rdata[0]                 = en_vec[i];
              rdata[1]                 = ie_vec[i];
              rdata[2]                 = pend_vec[i];
              rdata[3]                 = mode_vec[i];
              rdata[8 +: PRESC_WIDTH]  = presc_arr[i];
            end
            OFF_COUNT: rdata[CNT_WIDTH-1:0] = count_arr[i];
            OFF_VALUE: rdata[CNT_WIDTH-1:0] = value_arr[i];
            default:   rdata = '0;
          endcase
        end
      end
    end
  end

  // Registered read data and one-cycle acknowledge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_o  <= 1'b0;
      data_o <= '0;
    end else begin
      ack_o  <= req_i;
      data_o <= req_i ? rdata : '0;
    end
  end

  assign int_sig_o = |(pend_vec & ie_vec);

endmodule
`default_nettype wire

// File: tb/tb_timer_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_multi
// Purpose  : Directed self-checking bench for timer_multi with a read
//            scoreboard: expected read data is queued at request time and
//            compared when the acknowledge arrives.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_multi;

  logic        clk;
  logic        rst;
  logic [31:0] data_i;
  logic [31:0] addr_i;
  logic        we_i;
  logic        req_i;
  logic [31:0] data_o;
  logic        ack_o;
  logic        int_sig_o;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string       tag;
    logic [31:0] data;
    bit          dchk;
  } exp_t;

  exp_t sb[$];

  timer_multi #(.NUM_CH(4), .CNT_WIDTH(32), .PRESC_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_i    (data_i),
    .addr_i    (addr_i),
    .we_i      (we_i),
    .req_i     (req_i),
    .data_o    (data_o),
    .ack_o     (ack_o),
    .int_sig_o (int_sig_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One bus cycle: at the negedge, retire last cycle's request (if any),
  // then drive this cycle's request, which is applied on the next posedge.
  task automatic cycle(input bit rq, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp,
                       input bit dchk, input string tag);
    exp_t e;
    exp_t n;
    @(negedge clk);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, "_ack"}, {31'b0, ack_o}, 32'd1);
      if (e.dchk) chk(e.tag, data_o, e.data);
    end else begin
      chk("idle_ack", {31'b0, ack_o}, 32'd0);
    end
    req_i  = rq;
    we_i   = wr;
    addr_i = a;
    data_i = d;
    if (rq) begin
      n.tag  = tag;
      n.data = exp;
      n.dchk = dchk;
      sb.push_back(n);
    end
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    cycle(1'b1, 1'b0, a, 32'd0, exp, 1'b1, tag);
  endtask

  task automatic wrt(input logic [31:0] a, input logic [31:0] d);
    cycle(1'b1, 1'b1, a, d, 32'd0, 1'b0, "wr");
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, "idle");
  endtask

  initial begin
    rst    = 1'b0;
    req_i  = 1'b0;
    we_i   = 1'b0;
    addr_i = '0;
    data_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_data", data_o, 32'd0);
    chk("rst_ack", {31'b0, ack_o}, 32'd0);
    chk("rst_int", {31'b0, int_sig_o}, 32'd0);
    rst = 1'b1;

    // Reset while ch0 is counting and a read is outstanding.
    wrt(32'h08, 32'd50);
    wrt(32'h00, 32'h3);
    repeat (5) idle();
    rd(32'h04, 32'd5, "mid_count");
    @(posedge clk);
    #1;
    chk("mid_ack_pre", {31'b0, ack_o}, 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_ack", {31'b0, ack_o}, 32'd0);
    chk("mid_rst_data", data_o, 32'd0);
    chk("mid_rst_int", {31'b0, int_sig_o}, 32'd0);
    sb.delete();
    req_i = 1'b0;
    we_i  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    idle();
    chk("post_rst_int", {31'b0, int_sig_o}, 32'd0);
    rd(32'h00, 32'd0, "post_rst_ctrl");
    rd(32'h04, 32'd0, "post_rst_count");
    rd(32'h08, 32'd0, "post_rst_value");

    // One-shot on ch0: VALUE=5, presc=0.
    wrt(32'h08, 32'd5);
    wrt(32'h00, 32'h3);
    for (int k = 0; k < 6; k++) rd(32'h04, 32'(k), "os_count");
    chk("os_int_before", {31'b0, int_sig_o}, 32'd0);
    rd(32'h04, 32'd0, "os_count_wrap");
    chk("os_int_after", {31'b0, int_sig_o}, 32'd1);
    rd(32'h00, 32'h6, "os_ctrl");
    rd(32'h100, 32'h1, "os_status");
    wrt(32'h00, 32'h4);
    idle();
    chk("os_int_clr", {31'b0, int_sig_o}, 32'd0);

    // Auto-reload on ch2 with presc=2: period 12 cycles.
    wrt(32'h28, 32'd3);
    wrt(32'h20, 32'h20B);
    repeat (12) idle();
    chk("ar_int_11", {31'b0, int_sig_o}, 32'd0);
    idle();
    chk("ar_int_12", {31'b0, int_sig_o}, 32'd1);
    wrt(32'h20, 32'h20F);
    idle();
    chk("ar_int_w1c", {31'b0, int_sig_o}, 32'd0);
    rd(32'h20, 32'h20B, "ar_ctrl");
    rd(32'h24, 32'd1, "ar_count");
    repeat (7) idle();
    chk("ar_int_23", {31'b0, int_sig_o}, 32'd0);
    idle();
    chk("ar_int_24", {31'b0, int_sig_o}, 32'd1);
    wrt(32'h20, 32'h4);

    // W1C racing an expiry on ch1: set wins.
    wrt(32'h18, 32'd2);
    wrt(32'h10, 32'h3);
    idle();
    idle();
    wrt(32'h10, 32'h7);
    idle();
    chk("race_int", {31'b0, int_sig_o}, 32'd1);
    rd(32'h10, 32'h7, "race_ctrl");
    wrt(32'h10, 32'h0);
    wrt(32'h10, 32'h4);
    idle();
    chk("race_clr_int", {31'b0, int_sig_o}, 32'd0);

    // VALUE lowered below the running count on ch3.
    wrt(32'h38, 32'd200);
    wrt(32'h30, 32'h1);
    repeat (100) idle();
    rd(32'h34, 32'd100, "shrink_c100");
    wrt(32'h38, 32'd10);
    rd(32'h34, 32'd102, "shrink_c102");
    rd(32'h34, 32'd0, "shrink_expired");
    rd(32'h30, 32'h4, "shrink_ctrl");
    rd(32'h100, 32'h8, "shrink_status");
    chk("shrink_int", {31'b0, int_sig_o}, 32'd0);

    // Bus: back-to-back reads, pre-write data, absent channel.
    rd(32'h04, 32'd0, "b2b_count");
    rd(32'h0C, 32'd0, "b2b_unmapped");
    idle();
    cycle(1'b1, 1'b1, 32'h08, 32'h77, 32'd5, 1'b1, "prewrite_val");
    rd(32'h08, 32'h77, "value_rb");
    wrt(32'h40, 32'h3);
    wrt(32'h48, 32'h9);
    rd(32'h40, 32'd0, "absent_ctrl");
    rd(32'h48, 32'd0, "absent_value");
    rd(32'h00, 32'd0, "ch0_ctrl_alias");
    rd(32'h100, 32'h8, "final_status");
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
